// File: rtl/mat2x2_inv_seq_pkg.sv
// Shared Q2.14 constants, FSM encoding and saturation helper for the 2x2 inverse.
package mat2x2_inv_seq_pkg;
    localparam int WIDTH = 16;
    localparam int FRAC  = 14;
    localparam int QW    = 3*FRAC + 1;
    localparam int DW    = 2*WIDTH;
    localparam int CW    = $clog2(QW);
    localparam int PW    = WIDTH + QW + 2;
    localparam int Q_ONE = 16384;
    localparam int Q_MAX = 32767;
    localparam int Q_MIN = -32768;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DET   = 3'd1,
        DIV   = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic signed [WIDTH-1:0] sat16(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] hi, lo;
        hi = PW'(Q_MAX);
        lo = PW'(Q_MIN);
        if (v > hi)      sat16 = 16'sh7fff;
        else if (v < lo) sat16 = 16'sh8000;
        else             sat16 = v[WIDTH-1:0];
    endfunction
endpackage

// File: rtl/mat2x2_inv_seq_if.sv
// Request/response bundle between the Kalman gain sequencer and the 2x2 inverse.
interface mat2x2_inv_seq_if;
    import mat2x2_inv_seq_pkg::*;

    logic                    start;
    logic signed [WIDTH-1:0] a, b, c, d;
    logic signed [WIDTH-1:0] a_inv, b_inv, c_inv, d_inv;
    logic                    ready;
    logic                    error;
    logic                    busy;

    modport master (output start, a, b, c, d,
                    input  a_inv, b_inv, c_inv, d_inv, ready, error, busy);
    modport slave  (input  start, a, b, c, d,
                    output a_inv, b_inv, c_inv, d_inv, ready, error, busy);
endinterface

// File: rtl/mat2x2_inv_seq_recip.sv
// Restoring unsigned divider: floor(2^(3*FRAC) / divisor), one quotient bit per clock, MSB first.
module uq_recip_div
    import mat2x2_inv_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] divisor,
    output logic [QW-1:0] quotient,
    output logic          done
);
    logic [DW-1:0] dvs_q, rem_q, sub;
    logic [DW:0]   rem_sh;
    logic [QW-1:0] quo_q;
    logic [CW-1:0] cnt_q;
    logic          act_q, dbit, ge;

    // The dividend is a single set bit at position QW-1.
    assign dbit   = (cnt_q == CW'(QW-1));
    assign rem_sh = {rem_q, dbit};
    assign ge     = (rem_sh >= {1'b0, dvs_q});
    // When ge holds the true difference is below the divisor, so 32 bits suffice.
    assign sub    = rem_sh[DW-1:0] - dvs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (start) begin
            dvs_q <= divisor;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= CW'(QW-1);
            act_q <= 1'b1;
        end else if (act_q) begin
            rem_q <= ge ? sub : rem_sh[DW-1:0];
            quo_q <= {quo_q[QW-2:0], ge};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) act_q <= 1'b0;
        end
    end

    assign quotient = quo_q;
    assign done     = act_q && (cnt_q == '0);
endmodule

// File: rtl/mat2x2_inv_seq.sv
// Sequential signed Q2.14 2x2 inverse: det, one reciprocal, four scaled adjugate lanes.
module mat2x2_inv_seq
    import mat2x2_inv_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mat2x2_inv_seq_if.slave   bus
);
    state_t                      state, nxt;
    logic [3:0][WIDTH-1:0]       m_q, inv_q, scaled;
    logic signed [DW-1:0]        ad, bc;
    logic signed [DW:0]          det_f;
    logic [DW-1:0]               mag;
    logic                        det_zero, sgn_q, div_start, div_done;
    logic [QW-1:0]               quo;
    logic signed [QW:0]          qe, r;
    logic                        ready_q, busy_q, error_q;

    // Element order in m_q: 0=a, 1=b, 2=c, 3=d.
    assign ad       = DW'($signed(m_q[0])) * DW'($signed(m_q[3]));
    assign bc       = DW'($signed(m_q[1])) * DW'($signed(m_q[2]));
    assign det_f    = {ad[DW-1], ad} - {bc[DW-1], bc};
    assign det_zero = (det_f == '0);
    assign mag      = det_f[DW] ? DW'(-det_f) : det_f[DW-1:0];

    assign div_start = (state == DET) && !det_zero;

    uq_recip_div u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .divisor  (mag),
        .quotient (quo),
        .done     (div_done)
    );

    assign qe = {1'b0, quo};
    assign r  = sgn_q ? -qe : qe;

    // Adjugate lanes: a'=d, b'=-b, c'=-c, d'=a; the 17-bit lane keeps -(-32768) exact.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        localparam int SRC = (i == 0) ? 3 : (i == 3) ? 0 : i;
        localparam bit NEG = (i == 1) || (i == 2);
        logic signed [WIDTH:0]  ext, adj;
        logic signed [PW-1:0]   prod, shr;
        assign ext       = {m_q[SRC][WIDTH-1], m_q[SRC]};
        assign adj       = NEG ? -ext : ext;
        assign prod      = PW'(adj) * PW'(r);
        assign shr       = prod >>> FRAC;
        assign scaled[i] = sat16(shr);
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.start) nxt = DET;
            DET:     nxt = det_zero ? DONE : DIV;
            DIV:     if (div_done) nxt = SCALE;
            SCALE:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            m_q     <= '0;
            inv_q   <= '0;
            sgn_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= nxt;
            ready_q <= (nxt == DONE);
            busy_q  <= (nxt != IDLE);
            if (state == IDLE && bus.start) begin
                m_q     <= {bus.d, bus.c, bus.b, bus.a};
                error_q <= 1'b0;
            end
            if (state == DET) begin
                sgn_q <= det_f[DW];
                if (det_zero) begin
                    error_q <= 1'b1;
                    inv_q   <= '0;
                end
            end
            if (state == SCALE) inv_q <= scaled;
        end
    end

    assign bus.a_inv = inv_q[0];
    assign bus.b_inv = inv_q[1];
    assign bus.c_inv = inv_q[2];
    assign bus.d_inv = inv_q[3];
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.error = error_q;
endmodule

// File: tb/tb_mat2x2_inv_seq.sv
// Randomized bench for mat2x2_inv_seq against a plain-arithmetic inverse model.
module tb_mat2x2_inv_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;

    mat2x2_inv_seq_if bus ();

    mat2x2_inv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Inverse = adj(S) * (1/det), reciprocal as floor(2^42/|det|) with the sign applied after.
    function automatic void ref_inv(input longint a, b, c, d,
                                    output longint ea, eb, ec, ed, output bit err);
        longint det, q, rr;
        det = a*d - b*c;
        err = (det == 0);
        ea = 0; eb = 0; ec = 0; ed = 0;
        if (!err) begin
            q  = (longint'(1) <<< 42) / (det < 0 ? -det : det);
            rr = (det < 0) ? -q : q;
            ea = sat(( d * rr) >>> 14);
            eb = sat((-b * rr) >>> 14);
            ec = sat((-c * rr) >>> 14);
            ed = sat(( a * rr) >>> 14);
        end
    endfunction

    task automatic drive(input int a, b, c, d);
        bus.a = 16'(a); bus.b = 16'(b); bus.c = 16'(c); bus.d = 16'(d);
    endtask

    task automatic check_outs(input string tag, input longint ea, eb, ec, ed, input bit err);
        chk({tag, "_a"}, bus.a_inv, ea);
        chk({tag, "_b"}, bus.b_inv, eb);
        chk({tag, "_c"}, bus.c_inv, ec);
        chk({tag, "_d"}, bus.d_inv, ed);
        chk({tag, "_err"}, bus.error, err);
    endtask

    task automatic run_job(input int a, b, c, d);
        longint ea, eb, ec, ed;
        bit     err;
        int     lat;
        ref_inv(a, b, c, d, ea, eb, ec, ed, err);
        @(negedge clk);
        bus.start = 1'b1;
        drive(a, b, c, d);
        @(posedge clk); #1;
        lat = 1;
        bus.start = 1'b0;
        drive(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        chk("busy_acc", bus.busy, 1);
        while (!bus.ready && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, err ? 2 : 46);
        chk("busy_rdy", bus.busy, 1);
        check_outs("job", ea, eb, ec, ed, err);
        @(posedge clk); #1;
        chk("ready_pulse", bus.ready, 0);
        chk("busy_end", bus.busy, 0);
    endtask

    function automatic int rnd(input int lim);
        return int'($urandom_range(0, 2*lim)) - lim;
    endfunction

    initial begin
        longint ea, eb, ec, ed;
        bit     err;
        int     n, nrdy, lim, a, b, c, d;

        reset = 1'b0;
        bus.start = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.ready, 0);
        chk("rst_busy", bus.busy, 0);
        check_outs("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        run_job(16384, 0, 0, 16384);
        chk("ident_a", bus.a_inv, 16384);
        run_job(16384, 8192, 0, 16384);
        chk("upper_b", bus.b_inv, -8192);
        run_job(0, 16384, 16384, 0);
        chk("negdet_b", bus.b_inv, 16384);
        run_job(8192, 0, 0, 8192);
        chk("sat_a", bus.a_inv, 32767);
        run_job(16384, 16384, 16384, 16384);
        chk("sing_err", bus.error, 1);
        run_job(16384, 0, 0, 16384);
        chk("err_clear", bus.error, 0);
        run_job(-32768, -32768, 0, -32768);
        chk("min_neg_b", bus.b_inv, 8192);

        for (int i = 0; i < 40; i++) begin
            lim = (i % 4 == 0) ? 32767 : (i % 4 == 1) ? 4096 : 512;
            a = rnd(lim); b = rnd(lim); c = rnd(lim); d = rnd(lim);
            if (i % 4 == 3) begin b = a; d = c; end
            run_job(a, b, c, d);
        end

        // start held high: jobs run back-to-back with one idle cycle between.
        @(negedge clk);
        bus.start = 1'b1;
        drive(16384, 0, 0, 16384);
        n = 0;
        while (!bus.ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("b2b_first", bus.ready, 1);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!bus.ready && n < 200);
            chk("b2b_period", n, 47);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_drain", bus.busy, 0);

        // start pulsed during DIV must be ignored.
        ref_inv(16384, 8192, 0, 16384, ea, eb, ec, ed, err);
        @(negedge clk);
        bus.start = 1'b1;
        drive(16384, 8192, 0, 16384);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        drive(8192, 0, 0, 8192);
        @(negedge clk);
        bus.start = 1'b0;
        nrdy = 0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk); #1;
            if (bus.ready) nrdy++;
        end
        chk("div_ignore_rdy", nrdy, 1);
        check_outs("div_ignore", ea, eb, ec, ed, err);

        // reset mid-operation aborts the job.
        @(negedge clk);
        bus.start = 1'b1;
        drive(16384, 0, 0, 16384);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_ready", bus.ready, 0);
        check_outs("abort", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        nrdy = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (bus.ready) nrdy++;
        end
        chk("abort_no_rdy", nrdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
